// File: rtl/irq_pkg.sv
// Shared types and constants for the CP0 interrupt controller.
package irq_pkg;

  localparam int unsigned IRQ_N_SRC_DEF    = 4;
  localparam int unsigned IRQ_DEBOUNCE_DEF = 16;

  typedef enum logic [1:0] {
    IRQ_IDLE = 2'd0,
    IRQ_REQ  = 2'd1,
    IRQ_SVC  = 2'd2
  } irq_state_e;

  // Width of the granted-source index; never narrower than one bit.
  function automatic int unsigned irq_id_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/irq_if.sv
// Source, mask and CP0 handshake signals of the interrupt controller.
interface irq_if
  import irq_pkg::*;
#(
  parameter int unsigned N_SRC = IRQ_N_SRC_DEF,
  parameter int unsigned ID_W  = irq_id_w(N_SRC)
) ();

  logic [N_SRC-1:0] irq_src;
  logic             mask_wen;
  logic [N_SRC-1:0] mask_din;
  logic [N_SRC-1:0] irq_mask;
  logic [N_SRC-1:0] irq_pending;
  logic             ir_out;
  logic             ir_taken;
  logic             ir_return;
  logic [ID_W-1:0]  irq_id;
  logic             busy;

  modport master (
    output irq_src, mask_wen, mask_din, ir_taken, ir_return,
    input  irq_mask, irq_pending, ir_out, irq_id, busy
  );

  modport slave (
    input  irq_src, mask_wen, mask_din, ir_taken, ir_return,
    output irq_mask, irq_pending, ir_out, irq_id, busy
  );

endinterface

// File: rtl/irq_sync_edge.sv
// Per-source 2-flop synchroniser, optional stability filter and rising-edge detector.
// Define IRQ_DEBOUNCE_EN to insert the DEBOUNCE_CYCLES stability filter.
module irq_sync_edge
`ifdef IRQ_DEBOUNCE_EN
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16
)
`endif
(
  input  logic clk,
  input  logic rst,
  input  logic src_i,
  output logic rise_c_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;
  logic level;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= src_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef IRQ_DEBOUNCE_EN
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             filt_q;
  logic             filt_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Filtered level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync2_q != filt_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        filt_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      filt_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign level = filt_q;
`else
  assign level = sync2_q;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= level;
    end
  end

  assign rise_c_o = level & ~prev_q;

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller in front of CP0: pending/mask registers, fixed priority, request FSM.
// Define IRQ_DEBOUNCE_EN to add a DEBOUNCE_CYCLES stability filter on every source.
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int unsigned N_SRC = IRQ_N_SRC_DEF
`ifdef IRQ_DEBOUNCE_EN
  , parameter int unsigned DEBOUNCE_CYCLES = IRQ_DEBOUNCE_DEF
`endif
) (
  input  logic  clk,
  input  logic  rst,
  irq_if.slave  bus
);

  localparam int unsigned ID_W = irq_id_w(N_SRC);

  irq_state_e       state_q, state_d;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic             ir_out_q, ir_out_d;
  logic             busy_q, busy_d;
  logic [ID_W-1:0]  irq_id_q, irq_id_d;

  logic [N_SRC-1:0] rise_c;
  logic [N_SRC-1:0] eligible;
  logic [N_SRC-1:0] grant_clr;
  logic [ID_W-1:0]  winner;

  for (genvar g = 0; g < int'(N_SRC); g++) begin : g_src
    irq_sync_edge
`ifdef IRQ_DEBOUNCE_EN
      #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES))
`endif
      u_sync_edge (
        .clk      (clk),
        .rst      (rst),
        .src_i    (bus.irq_src[g]),
        .rise_c_o (rise_c[g])
      );
  end

  assign eligible = pending_q & mask_q;

  // Lowest set index wins.
  always_comb begin
    winner = '0;
    for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        winner = ID_W'(i);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ir_out_d  = ir_out_q;
    busy_d    = busy_q;
    irq_id_d  = irq_id_q;
    grant_clr = '0;
    mask_d    = bus.mask_wen ? bus.mask_din : mask_q;

    unique case (state_q)
      IRQ_IDLE: begin
        if (|eligible) begin
          irq_id_d          = winner;
          grant_clr[winner] = 1'b1;
          ir_out_d          = 1'b1;
          busy_d            = 1'b1;
          state_d           = IRQ_REQ;
        end
      end
      IRQ_REQ: begin
        // ir_taken has priority over a simultaneous ir_return here.
        if (bus.ir_taken) begin
          ir_out_d = 1'b0;
          state_d  = IRQ_SVC;
        end
      end
      IRQ_SVC: begin
        if (bus.ir_return) begin
          busy_d  = 1'b0;
          state_d = IRQ_IDLE;
        end
      end
      default: begin
        ir_out_d = 1'b0;
        busy_d   = 1'b0;
        state_d  = IRQ_IDLE;
      end
    endcase

    // A fresh edge overrides the grant clear on the same source.
    pending_d = (pending_q & ~grant_clr) | rise_c;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IRQ_IDLE;
      mask_q    <= '0;
      pending_q <= '0;
      ir_out_q  <= 1'b0;
      busy_q    <= 1'b0;
      irq_id_q  <= '0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      pending_q <= pending_d;
      ir_out_q  <= ir_out_d;
      busy_q    <= busy_d;
      irq_id_q  <= irq_id_d;
    end
  end

  assign bus.irq_mask    = mask_q;
  assign bus.irq_pending = pending_q;
  assign bus.ir_out      = ir_out_q;
  assign bus.busy        = busy_q;
  assign bus.irq_id      = irq_id_q;

endmodule
